ntt_masked_pwm_pipe: RTL and testbench

Multi-lane, valid-tagged masked pointwise-multiply(-accumulate) pipeline for the NTT datapath. Each of `NUM_LANES` lanes computes `u·v` or `u·v + w` on two-share masked operands. The accumulate choice is made per transaction rather than statically, and all modes share one fixed latency. The block sits between the NTT memory read path and the masked write-back path. It issues its own accumulate-operand read request, tracks in-flight work, and flushes cleanly on zeroize or reset.

---
 rtl/ntt_defines_pkg.sv | 9 +
 rtl/ntt_masked_BFU_add_sub.sv | 35 +++
 rtl/ntt_masked_BFU_mult.sv | 34 +++
 rtl/ntt_masked_pwm_lane.sv | 51 +++++
 rtl/ntt_masked_pwm_pipe.sv | 75 +++++++
 tb/tb_ntt_masked_pwm_pipe.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ntt_defines_pkg.sv
// Shared constants and share typedef for the masked NTT pointwise-multiply datapath.
package ntt_defines_pkg;
  localparam int MASKED_PWM_WIDTH   = 46;
  localparam int MASKED_PWM_MUL_LAT = 210;
  localparam int MASKED_PWM_ADD_LAT = 53;
  localparam int MASKED_PWM_LAT     = MASKED_PWM_MUL_LAT + 1 + MASKED_PWM_ADD_LAT;

  typedef logic [1:0][MASKED_PWM_WIDTH-1:0] masked_share_t;
endpackage

// File: rtl/ntt_masked_BFU_add_sub.sv
// Two-share masked add/subtract mod 2^WIDTH, LAT-cycle pipeline, no backpressure.
module ntt_masked_BFU_add_sub #(
  parameter int WIDTH = 46,
  parameter int LAT   = 53
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_sub,
  input  logic [1:0][WIDTH-1:0]  i_a,
  input  logic [1:0][WIDTH-1:0]  i_b,
  input  logic [WIDTH-1:0]       i_rnd,
  output logic [1:0][WIDTH-1:0]  o_res
);
  logic [WIDTH-1:0]      w_s0;
  logic [WIDTH-1:0]      w_s1;
  logic [1:0][WIDTH-1:0] r_pipe [LAT];

  // Share-wise operation with a fresh refresh term that cancels on recombination.
  assign w_s0 = (i_sub ? (i_a[0] - i_b[0]) : (i_a[0] + i_b[0])) + i_rnd;
  assign w_s1 = (i_sub ? (i_a[1] - i_b[1]) : (i_a[1] + i_b[1])) - i_rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_s1, w_s0};
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_res = r_pipe[LAT-1];
endmodule

// File: rtl/ntt_masked_BFU_mult.sv
// Two-share masked multiplier mod 2^WIDTH, LAT-cycle pipeline, no backpressure.
module ntt_masked_BFU_mult #(
  parameter int WIDTH = 46,
  parameter int LAT   = 210
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic [1:0][WIDTH-1:0]  i_a,
  input  logic [1:0][WIDTH-1:0]  i_b,
  input  logic [3:0][WIDTH-1:0]  i_rnd,
  output logic [1:0][WIDTH-1:0]  o_res
);
  logic [WIDTH-1:0]      w_s0;
  logic [WIDTH-1:0]      w_s1;
  logic [1:0][WIDTH-1:0] r_pipe [LAT];

  // Every cross product is refreshed with randomness before it joins a share sum.
  assign w_s0 = (i_a[0] * i_b[0] + i_rnd[0]) + (i_a[0] * i_b[1] + i_rnd[1]) + i_rnd[2] - i_rnd[3];
  assign w_s1 = (i_a[1] * i_b[0] - i_rnd[0]) + (i_a[1] * i_b[1] - i_rnd[1]) - i_rnd[2] + i_rnd[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_s1, w_s0};
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_res = r_pipe[LAT-1];
endmodule

// File: rtl/ntt_masked_pwm_lane.sv
// One masked PWM/PWMA lane: multiply, product register, gated w add.
// Latency MUL_LAT + 1 + ADD_LAT; no backpressure.
module ntt_masked_pwm_lane #(
  parameter int WIDTH   = 46,
  parameter int MUL_LAT = 210,
  parameter int ADD_LAT = 53
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic [1:0][WIDTH-1:0]  i_u,
  input  logic [1:0][WIDTH-1:0]  i_v,
  input  logic [4:0][WIDTH-1:0]  i_rnd,
  input  logic [1:0][WIDTH-1:0]  i_w,
  input  logic                   i_w_en,
  output logic [1:0][WIDTH-1:0]  o_res
);
  logic [1:0][WIDTH-1:0] w_mul;
  logic [1:0][WIDTH-1:0] r_prod;
  logic [1:0][WIDTH-1:0] w_w_gated;

  ntt_masked_BFU_mult #(.WIDTH(WIDTH), .LAT(MUL_LAT)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_clr),
    .i_a   (i_u),
    .i_b   (i_v),
    .i_rnd (i_rnd[3:0]),
    .o_res (w_mul)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_prod <= '0;
    else if (i_clr) r_prod <= '0;
    else            r_prod <= w_mul;
  end

  // PWM transactions add zero so both modes share the same path and latency.
  assign w_w_gated = i_w_en ? i_w : '0;

  ntt_masked_BFU_add_sub #(.WIDTH(WIDTH), .LAT(ADD_LAT)) u_add (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_clr),
    .i_sub (1'b0),
    .i_a   (r_prod),
    .i_b   (w_w_gated),
    .i_rnd (i_rnd[4]),
    .o_res (o_res)
  );
endmodule

// File: rtl/ntt_masked_pwm_pipe.sv
// Multi-lane masked pointwise multiply(-accumulate), fixed latency MUL_LAT+1+ADD_LAT.
// Accepts one transaction per cycle and never back-pressures; w is fetched on its own request.
module ntt_masked_pwm_pipe
  import ntt_defines_pkg::*;
#(
  parameter  int WIDTH     = MASKED_PWM_WIDTH,
  parameter  int NUM_LANES = 4,
  parameter  int MUL_LAT   = MASKED_PWM_MUL_LAT,
  parameter  int ADD_LAT   = MASKED_PWM_ADD_LAT,
  localparam int LAT       = MUL_LAT + 1 + ADD_LAT,
  localparam int CNT_W     = $clog2(LAT + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 zeroize,
  input  logic                                 in_valid,
  input  logic                                 accumulate,
  input  logic [NUM_LANES-1:0][1:0][WIDTH-1:0] u,
  input  logic [NUM_LANES-1:0][1:0][WIDTH-1:0] v,
  input  logic [NUM_LANES-1:0][4:0][WIDTH-1:0] rnd,
  output logic                                 w_req,
  input  logic [NUM_LANES-1:0][1:0][WIDTH-1:0] w,
  output logic                                 out_valid,
  output logic [NUM_LANES-1:0][1:0][WIDTH-1:0] res,
  output logic                                 busy,
  output logic [CNT_W-1:0]                     inflight
);
  // Bit k of each shift register holds the transaction accepted k cycles ago.
  logic [LAT:1]       r_vld;
  logic [MUL_LAT+1:1] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (zeroize) begin
      r_vld <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_vld <= {r_vld[LAT-1:1], in_valid};
      r_acc <= {r_acc[MUL_LAT:1], in_valid & accumulate};
      case ({in_valid, r_vld[LAT]})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_req     = r_vld[MUL_LAT] & r_acc[MUL_LAT];
  assign out_valid = r_vld[LAT];
  assign inflight  = r_cnt;
  assign busy      = (r_cnt != '0);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ntt_masked_pwm_lane #(
      .WIDTH   (WIDTH),
      .MUL_LAT (MUL_LAT),
      .ADD_LAT (ADD_LAT)
    ) u_lane (
      .clk    (clk),
      .rst    (reset),
      .i_clr  (zeroize),
      .i_u    (u[g]),
      .i_v    (v[g]),
      .i_rnd  (rnd[g]),
      .i_w    (w[g]),
      .i_w_en (r_acc[MUL_LAT+1]),
      .o_res  (res[g])
    );
  end
endmodule

// File: tb/tb_ntt_masked_pwm_pipe.sv
// Bench for ntt_masked_pwm_pipe: vector table plus scoreboard and cycle-indexed reference of valid/w_req/inflight.
module tb_ntt_masked_pwm_pipe;
  import ntt_defines_pkg::*;

  localparam int W   = 46;
  localparam int NL  = 4;
  localparam int MUL = MASKED_PWM_MUL_LAT;
  localparam int LAT = MASKED_PWM_LAT;
  localparam int CW  = $clog2(LAT + 1);
  localparam int HN  = 8192;

  typedef logic [NL-1:0][1:0][W-1:0] lane_t;
  typedef logic [NL-1:0][4:0][W-1:0] rnd_t;
  typedef logic [NL-1:0][W-1:0]      rec_t;
  typedef struct { int cyc; rec_t exp; }  sb_t;
  typedef struct { int cyc; lane_t w; }   wq_t;
  typedef struct {
    logic [W-1:0] u0, u1, v0, v1, w0, w1;
    logic         acc;
    logic [W-1:0] exp;
  } vec_t;

  logic    clk = 0, reset = 1, zeroize = 0, in_valid = 0, accumulate = 0;
  lane_t   u = '0, v = '0, w = '0, res;
  rnd_t    rnd = '0;
  logic    w_req, out_valid, busy;
  logic [CW-1:0] inflight;

  int  checks = 0, errors = 0, cyc = 0, flush = 0, peak = 0;
  bit  vhist [HN];
  bit  ahist [HN];
  bit  want_w = 0;
  sb_t sbq [$];
  wq_t wq  [$];
  vec_t tbl [8];

  ntt_masked_pwm_pipe dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .in_valid(in_valid),
    .accumulate(accumulate), .u(u), .v(v), .rnd(rnd), .w_req(w_req), .w(w),
    .out_valid(out_valid), .res(res), .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rw();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic lane_t rand_lane();
    lane_t l;
    for (int i = 0; i < NL; i++) for (int s = 0; s < 2; s++) l[i][s] = rw();
    return l;
  endfunction

  function automatic rnd_t rand_rnd();
    rnd_t r;
    for (int i = 0; i < NL; i++) for (int s = 0; s < 5; s++) r[i][s] = rw();
    return r;
  endfunction

  function automatic rec_t golden(input logic a, input lane_t uu, input lane_t vv, input lane_t ww);
    rec_t r;
    logic [W-1:0] us, vs, ws;
    for (int i = 0; i < NL; i++) begin
      us = uu[i][0] + uu[i][1];
      vs = vv[i][0] + vv[i][1];
      ws = ww[i][0] + ww[i][1];
      r[i] = us * vs + (a ? ws : '0);
    end
    return r;
  endfunction

  // Reference of valid / w_req / inflight derived from the input history.
  int   exp_inf;
  logic exp_wr, exp_ov;
  logic [W-1:0] sum;
  sb_t  e;
  always @(negedge clk) begin
    if (reset) flush = cyc + 1;
    if (cyc < HN) begin
      vhist[cyc] = in_valid && !zeroize && !reset;
      ahist[cyc] = accumulate;
      exp_wr = (cyc >= MUL) && (cyc - MUL >= flush) && vhist[cyc-MUL] && ahist[cyc-MUL];
      exp_ov = (cyc >= LAT) && (cyc - LAT >= flush) && vhist[cyc-LAT];
      exp_inf = 0;
      for (int i = (flush > cyc - LAT ? flush : cyc - LAT); i < cyc; i++)
        if (i >= 0 && vhist[i]) exp_inf++;
      chk("w_req", w_req, exp_wr);
      chk("out_valid", out_valid, exp_ov);
      chk("inflight", inflight, exp_inf);
      chk("busy", busy, exp_inf != 0);
    end
    if (out_valid) begin
      while (sbq.size() > 0 && sbq[0].cyc < flush) void'(sbq.pop_front());
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow at cycle %0d: got out_valid with no expected result", cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc - e.cyc, LAT);
        for (int l = 0; l < NL; l++) begin
          sum = res[l][0] + res[l][1];
          chk("res_recombined", sum, e.exp[l]);
        end
      end
    end
    if (inflight > peak) peak = inflight;
    want_w = w_req;
    if (zeroize) flush = cyc + 1;
  end

  // Supplies w only on the cycle after w_req; random noise on every other cycle.
  always @(posedge clk) begin
    #1;
    if (want_w) begin
      while (wq.size() > 0 && wq[0].cyc < flush) void'(wq.pop_front());
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL w_underflow at cycle %0d: w_req with no pending PWMA", cyc);
        w = rand_lane();
      end else begin
        w = wq.pop_front().w;
      end
    end else begin
      w = rand_lane();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rnd = rand_rnd();
  endtask

  task automatic send(input logic a, input lane_t uu, input lane_t vv, input lane_t ww, input rec_t ex);
    sb_t s;
    wq_t q;
    in_valid = 1; accumulate = a; u = uu; v = vv;
    s.cyc = cyc; s.exp = ex; sbq.push_back(s);
    if (a) begin q.cyc = cyc; q.w = ww; wq.push_back(q); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      in_valid = 0; accumulate = 0; u = rand_lane(); v = rand_lane();
    end
  endtask

  task automatic purge();
    while (sbq.size() > 0 && sbq[0].cyc < flush) void'(sbq.pop_front());
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < LAT + 40) begin idle(1); n++; end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", nm, sbq.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    lane_t uu, vv, ww;
    rec_t  ex;
    int    s;
    logic  a;

    tbl[0] = '{46'd3, 46'd0, 46'd5, 46'd0, 46'd0, 46'd0, 1'b0, 46'd15};
    tbl[1] = '{46'd3, 46'd0, 46'd5, 46'd0, 46'd7, 46'd0, 1'b1, 46'd22};
    tbl[2] = '{46'd1, 46'd2, 46'd5, 46'd0, 46'd0, 46'd0, 1'b0, 46'd15};
    tbl[3] = '{46'd2, 46'd1, 46'd5, 46'd0, 46'd0, 46'd0, 1'b0, 46'd15};
    tbl[4] = '{46'd1, 46'd2, 46'd2, 46'd3, 46'd3, 46'd4, 1'b1, 46'd22};
    tbl[5] = '{46'h3FFF_FFFF_FFFF, 46'd0, 46'd2, 46'd0, 46'd0, 46'd0, 1'b0, 46'h3FFF_FFFF_FFFE};
    tbl[6] = '{46'h3FFF_FFFF_FFFF, 46'd2, 46'd4, 46'h3FFF_FFFF_FFFF, 46'd10, 46'h3FFF_FFFF_FFFB, 1'b1, 46'd8};
    tbl[7] = '{46'h2000_0000_0000, 46'h2000_0000_0000, 46'd9, 46'd9, 46'd0, 46'd0, 1'b1, 46'd0};

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_w_req", w_req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_res", res, 0);
    repeat (2) @(posedge clk);
    #3 reset = 0;

    // Single transactions from the vector table, one at a time.
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < NL; l++) begin
        uu[l][0] = tbl[k].u0; uu[l][1] = tbl[k].u1;
        vv[l][0] = tbl[k].v0; vv[l][1] = tbl[k].v1;
        ww[l][0] = tbl[k].w0; ww[l][1] = tbl[k].w1;
        ex[l]    = tbl[k].exp;
      end
      step();
      send(tbl[k].acc, uu, vv, ww, ex);
      idle(1);
      wait_drain("vector");
    end

    // Back-to-back alternating PWM/PWMA stream.
    peak = 0;
    for (int i = 0; i < 300; i++) begin
      a = i[0]; uu = rand_lane(); vv = rand_lane(); ww = rand_lane();
      step();
      send(a, uu, vv, ww, golden(a, uu, vv, ww));
    end
    idle(1);
    wait_drain("stream");
    chk("inflight_peak", peak, LAT);

    // Zeroize at t=100 with 50 transactions in flight; the zeroize-cycle input is dropped.
    for (int i = 0; i < 50; i++) begin
      a = $urandom_range(0, 1); uu = rand_lane(); vv = rand_lane(); ww = rand_lane();
      step();
      send(a, uu, vv, ww, golden(a, uu, vv, ww));
    end
    idle(50);
    step();
    uu = rand_lane(); vv = rand_lane(); ww = rand_lane();
    send(1'b1, uu, vv, ww, golden(1'b1, uu, vv, ww));
    zeroize = 1;
    step();
    zeroize = 0; in_valid = 0; accumulate = 0;
    @(negedge clk);
    chk("zeroize_inflight", inflight, 0);
    chk("zeroize_busy", busy, 0);
    idle(LAT + 20);
    purge();
    chk("zeroize_discard", sbq.size(), 0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 100; i++) begin
      a = i[0]; uu = rand_lane(); vv = rand_lane(); ww = rand_lane();
      step();
      send(a, uu, vv, ww, golden(a, uu, vv, ww));
    end
    idle(180);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_w_req", w_req, 0);
    chk("async_busy", busy, 0);
    chk("async_inflight", inflight, 0);
    chk("async_res", res, 0);
    repeat (2) @(posedge clk);
    #3 reset = 0;
    purge();
    for (int l = 0; l < NL; l++) begin
      uu[l][0] = 46'd3; uu[l][1] = 46'd0; vv[l][0] = 46'd5; vv[l][1] = 46'd0;
      ww[l] = '0; ex[l] = 46'd15;
    end
    step();
    send(1'b0, uu, vv, ww, ex);
    s = cyc;
    idle(1);
    for (int n = 0; n < LAT + 40; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("post_reset_latency", cyc - s, LAT);
    idle(2);
    wait_drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
